hex_segment_decoder: RTL and testbench
======================================

HEX_SEGMENT_DECODER -- requirements
Module: hex_segment_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clock and resetn.
REQ-002 Ports SHALL be as follows:
- clock, input, 1 bit: rising-edge clock.
- resetn, input, 1 bit: asynchronous active-low reset.
- seg_in, input, 7 bits: active-low segment code; bit0 is segment a and bit6 is segment g; 1 means the segment is off.
- seg_valid, input, 1 bit: seg_in carries a code this cycle.
- seg_ready, output, 1 bit: the block accepts a code this cycle.
- byte_out, output, 8 bits: assembled byte; high digit in [7:4], low digit in [3:0].
- byte_valid, output, 1 bit: byte_out is valid.
- byte_ready, input, 1 bit: the consumer accepts byte_out.
- code_err, output, 1 bit: one-cycle pulse when an accepted code is not in the table.
- err_count, output, 8 bits: saturating count of invalid codes.

Function
REQ-003 A code SHALL be accepted on a rising edge where seg_valid=1 and seg_ready=1.
REQ-004 seg_ready SHALL be 1 in states IDLE and HIGH, and 0 in state FULL.
REQ-005 Decoding SHALL use the 16-entry table SEG_CODE[0..15], which is identical to the team's 4-bit-to-7-segment encoder. Required entries include 0=0x40, 1=0x79, 6=0x02, 7=0x78 and 8=0x00.
REQ-006 An accepted code SHALL decode to the index of its exact match in SEG_CODE; partial or nearest matching SHALL NOT be performed.
REQ-007 The FSM SHALL have three states:
- IDLE: waiting for the high digit.
- HIGH: the high digit is held; waiting for the low digit.
- FULL: the byte is held; waiting for the consumer.
REQ-008 Transitions on an accepted valid code SHALL be:
- IDLE -> HIGH, storing the nibble in byte_out[7:4].
- HIGH -> FULL, storing the nibble in byte_out[3:0].
REQ-009 An accepted invalid code SHALL return the FSM to IDLE from IDLE or HIGH, SHALL discard any held high nibble, SHALL pulse code_err on the following cycle, and SHALL increment err_count.
REQ-010 err_count SHALL saturate at 0xFF; it SHALL NOT wrap to 0x00.
REQ-011 byte_valid SHALL be 1 exactly while in FULL.
REQ-012 byte_out SHALL be held stable while byte_valid=1 and byte_ready=0.
REQ-013 FULL -> IDLE SHALL occur on a rising edge where byte_ready=1.
REQ-014 No code SHALL be accepted in the cycle FULL exits; the first new code SHALL be accepted in IDLE on the next cycle.
REQ-015 Latency SHALL be one cycle: byte_valid rises on the cycle after the low-digit acceptance edge.
REQ-016 Sustained throughput SHALL be one byte per three cycles when the consumer holds byte_ready=1.
REQ-017 seg_valid=0 SHALL leave the state and registers unchanged.
REQ-018 The blank code 0x7F SHALL be treated as invalid.
REQ-019 All outputs SHALL be registered or SHALL be decoded only from the state register; there SHALL be no combinational path from seg_in to any output.

Reset
REQ-020 Asserting resetn low SHALL immediately set the following, regardless of clock:
- FSM state to IDLE.
- byte_out to 0x00.
- byte_valid to 0.
- code_err to 0.
- err_count to 0x00.
- seg_ready to 1.
REQ-021 Reset asserted in HIGH or FULL SHALL discard the partial or held byte; no byte_valid pulse SHALL follow reset release.
REQ-022 The first code accepted on or after the first rising edge following resetn release SHALL be treated as a high digit.

Structure
REQ-023 A shared package SHALL hold the following:
- The SEG_CODE table constant.
- The state encoding constants IDLE=2'd0, HIGH=2'd1 and FULL=2'd2.
- The constant SEG_BLANK=7'h7F.
REQ-024 One combinational sub-module, seg7_to_nibble (inputs seg[6:0]; outputs nibble[3:0] and hit), SHALL perform the table match.
REQ-025 The FSM, data registers and error counter SHALL reside in hex_segment_decoder.
REQ-026 The unused state encoding 2'd3 SHALL recover to IDLE on the next clock.

Verification
REQ-027 The bench SHALL run a basic pair: 0x79 then 0x40 with byte_ready=1. Required: byte_out=0x10, with byte_valid=1 for one cycle starting one cycle after the second acceptance.
REQ-028 The bench SHALL check backpressure: codes 0x02 then 0x78 with byte_ready=0 for 5 cycles. Required: byte_out=0x67 held, seg_ready=0 throughout, and release on the first byte_ready=1 edge.
REQ-029 The bench SHALL check invalid-mid-byte handling: 0x00, then 0x7F, then 0x79, then 0x40. Required: one code_err pulse, err_count=1, and byte_out=0x10 (the 8 is discarded).
REQ-030 The bench SHALL check saturation: 260 invalid codes. Required: err_count=0xFF, with 256 or more code_err pulses observed.
REQ-031 The bench SHALL check reset in HIGH: 0x79 accepted, then resetn pulsed low between edges. Required: outputs at reset values immediately, and the next pair 0x40, 0x79 yields 0x01.
REQ-032 The bench SHALL run an exhaustive sweep: all 128 seg_in values paired with 0x40. Required: exactly 16 bytes produced, matching SEG_CODE indices, and err_count=0x70.

Source files
------------

// File: rtl/hex_segment_decoder_pkg.sv
// Shared constants for the seven-segment to byte decoder: segment table,
// FSM state encoding and the blank code.
package hex_segment_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba codes, same table as the nibble-to-segment encoder.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_segment_decoder_if.sv
// Segment-code input and byte-output handshake bundle.
interface hex_segment_decoder_if;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       code_err;
    logic [7:0] err_count;

    modport slave (
        input  seg_in, seg_valid, byte_ready,
        output seg_ready, byte_out, byte_valid, code_err, err_count
    );

    modport master (
        output seg_in, seg_valid, byte_ready,
        input  seg_ready, byte_out, byte_valid, code_err, err_count
    );
endinterface

// File: rtl/hex_segment_decoder_seg7.sv
// Exact-match lookup of a segment code against SEG_CODE; no nearest matching.
module seg7_to_nibble
    import hex_segment_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);
    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hex_segment_decoder.sv
// Assembles two decoded segment digits into a byte (high digit first) and
// counts invalid codes with a saturating counter.
module hex_segment_decoder
    import hex_segment_decoder_pkg::*;
(
    input  logic                        clock,
    input  logic                        resetn,
    hex_segment_decoder_if.slave        bus
);
    state_t     r_state, w_state_nxt;
    logic [7:0] r_byte;
    logic       r_code_err;
    logic [7:0] r_err_count;

    logic [3:0] w_nib;
    logic       w_match, w_hit, w_ready, w_accept;
    logic       w_load_hi, w_load_lo, w_bad;

    seg7_to_nibble u_lookup (
        .seg    (bus.seg_in),
        .nibble (w_nib),
        .hit    (w_match)
    );

    assign w_hit    = w_match && (bus.seg_in != SEG_BLANK);
    assign w_ready  = (r_state == IDLE) || (r_state == HIGH);
    assign w_accept = bus.seg_valid && w_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_hi   = 1'b0;
        w_load_lo   = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_state_nxt = HIGH;
                        w_load_hi   = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_state_nxt = FULL;
                        w_load_lo   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_bad       = 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.byte_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // An invalid code clears any half-built byte so no stale high digit survives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_byte      <= 8'h00;
            r_code_err  <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_code_err <= w_bad;
            if (w_load_hi)      r_byte      <= {w_nib, 4'h0};
            else if (w_load_lo) r_byte[3:0] <= w_nib;
            else if (w_bad)     r_byte      <= 8'h00;
            if (w_bad && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.seg_ready  = w_ready;
    assign bus.byte_valid = (r_state == FULL);
    assign bus.byte_out   = r_byte;
    assign bus.code_err   = r_code_err;
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_hex_segment_decoder.sv
// Bench for hex_segment_decoder: vector table, scoreboard queue fed by a
// reference model, and directed sequences for backpressure, errors and reset.
`timescale 1ns/1ps
module tb_hex_segment_decoder;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    hex_segment_decoder_if bus();

    hex_segment_decoder dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    localparam logic [6:0] TB_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [6:0] hi;
        logic [6:0] lo;
        logic [7:0] exp;
    } vec_t;

    int         pass_cnt = 0;
    int         tot_cnt  = 0;
    logic [7:0] exp_q [$];
    int         err_pulses = 0;
    int         bytes_seen = 0;
    int         cyc = 0;
    logic       m_have_hi = 1'b0;
    logic [3:0] m_hi = 4'h0;
    int         m_err = 0;

    always @(posedge clock) cyc++;

    function automatic void chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic int tb_decode(input logic [6:0] c);
        for (int i = 0; i < 16; i++)
            if (TB_SEG[i] == c) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for seg_ready, presents one code for one edge, updates the model.
    task automatic send_code(input logic [6:0] c);
        int n;
        int d;
        n = 0;
        while (!bus.seg_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.seg_ready) begin
            chk("seg_ready_timeout", 0, 1);
            return;
        end
        bus.seg_in    = c;
        bus.seg_valid = 1'b1;
        tick();
        bus.seg_valid = 1'b0;
        d = tb_decode(c);
        if (d < 0) begin
            m_have_hi = 1'b0;
            if (m_err < 255) m_err++;
        end else if (!m_have_hi) begin
            m_have_hi = 1'b1;
            m_hi      = d[3:0];
        end else begin
            exp_q.push_back({m_hi, d[3:0]});
            m_have_hi = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_out"},   bus.byte_out,   8'h00);
        chk({tag, "_byte_valid"}, bus.byte_valid, 0);
        chk({tag, "_code_err"},   bus.code_err,   0);
        chk({tag, "_err_count"},  bus.err_count,  8'h00);
        chk({tag, "_seg_ready"},  bus.seg_ready,  1);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (bus.code_err) err_pulses++;
            if (bus.byte_valid && bus.byte_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) chk("sb_unexpected_byte", bus.byte_out, -1);
                else                   chk("sb_byte", bus.byte_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int c0, p0, b0;

        vecs[0] = '{hi: 7'h24, lo: 7'h30, exp: 8'h23};
        vecs[1] = '{hi: 7'h19, lo: 7'h12, exp: 8'h45};
        vecs[2] = '{hi: 7'h10, lo: 7'h08, exp: 8'h9A};
        vecs[3] = '{hi: 7'h03, lo: 7'h46, exp: 8'hBC};
        vecs[4] = '{hi: 7'h21, lo: 7'h06, exp: 8'hDE};
        vecs[5] = '{hi: 7'h0E, lo: 7'h40, exp: 8'hF0};

        bus.seg_in     = 7'h7F;
        bus.seg_valid  = 1'b0;
        bus.byte_ready = 1'b1;
        #12;
        chk_reset_vals("reset");
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            send_code(vecs[i].hi);
            send_code(vecs[i].lo);
            chk("vec_valid", bus.byte_valid, 1);
            chk("vec_byte", bus.byte_out, vecs[i].exp);
            tick();
            chk("vec_valid_drop", bus.byte_valid, 0);
        end

        // Basic pair: one-cycle latency, one-cycle valid with consumer ready.
        send_code(7'h79);
        send_code(7'h40);
        chk("basic_valid", bus.byte_valid, 1);
        chk("basic_byte", bus.byte_out, 8'h10);
        tick();
        chk("basic_valid_one_cycle", bus.byte_valid, 0);

        // Back-to-back pairs: four bytes should take twelve cycles.
        c0 = cyc;
        send_code(7'h24); send_code(7'h19);
        send_code(7'h12); send_code(7'h02);
        send_code(7'h78); send_code(7'h00);
        send_code(7'h10); send_code(7'h40);
        tick();
        chk("throughput_cycles", cyc - c0, 12);

        // Backpressure.
        bus.byte_ready = 1'b0;
        send_code(7'h02);
        send_code(7'h78);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", bus.byte_valid, 1);
            chk("bp_seg_ready", bus.seg_ready, 0);
            chk("bp_byte", bus.byte_out, 8'h67);
            tick();
        end
        bus.byte_ready = 1'b1;
        tick();
        chk("bp_release", bus.byte_valid, 0);
        chk("bp_ready_back", bus.seg_ready, 1);

        // Invalid code after a held high digit.
        p0 = err_pulses;
        send_code(7'h00);
        send_code(7'h7F);
        chk("mid_code_err", bus.code_err, 1);
        chk("mid_err_count", bus.err_count, 1);
        tick();
        chk("mid_code_err_pulse", bus.code_err, 0);
        send_code(7'h79);
        send_code(7'h40);
        chk("mid_byte", bus.byte_out, 8'h10);
        tick();
        chk("mid_pulse_count", err_pulses - p0, 1);
        chk("mid_err_model", bus.err_count, m_err);

        // Saturation.
        p0 = err_pulses;
        repeat (260) send_code(7'h7F);
        tick();
        tick();
        chk("sat_err_count", bus.err_count, 8'hFF);
        chk("sat_pulses_ge_256", int'((err_pulses - p0) >= 256), 1);

        // Reset while holding a high digit.
        send_code(7'h79);
        #2 resetn = 1'b0;
        #1;
        chk_reset_vals("rst_high");
        m_have_hi = 1'b0;
        m_err     = 0;
        exp_q.delete();
        resetn = 1'b1;
        tick();
        tick();
        chk("rst_no_valid", bus.byte_valid, 0);
        send_code(7'h40);
        send_code(7'h79);
        chk("rst_pair_byte", bus.byte_out, 8'h01);
        tick();

        // Sweep every code as the low digit after 0x40.
        b0 = bytes_seen;
        for (int v = 0; v < 128; v++) begin
            send_code(7'h40);
            send_code(7'(v));
        end
        tick();
        tick();
        chk("sweep_bytes", bytes_seen - b0, 16);
        chk("sweep_err_count", bus.err_count, 8'h70);
        chk("sweep_err_model", bus.err_count, m_err);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
